mdu_iterative: RTL and testbench



---
 rtl/mdu_iterative_pkg.sv | 16 +
 rtl/mdu_iterative_step.sv | 32 +++
 rtl/mdu_iterative.sv | 141 ++++++++++++++
 tb/tb_mdu_iterative.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_iterative_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation codes
// and sequencer state encodings.
package mdu_iterative_pkg;

    localparam logic [1:0] MDU_OP_MULT  = 2'b00;
    localparam logic [1:0] MDU_OP_MULTU = 2'b01;
    localparam logic [1:0] MDU_OP_DIV   = 2'b10;
    localparam logic [1:0] MDU_OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        MDU_S_IDLE = 2'b00,
        MDU_S_CALC = 2'b01,
        MDU_S_FIX  = 2'b10
    } mdu_state_e;

endpackage

// File: rtl/mdu_iterative_step.sv
// One iteration of the MDU datapath: shift-add multiply step or restoring
// divide step on the combined {upper, lower} accumulator.
module mdu_iterative_step #(
    parameter int WIDTH = 32
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // Multiply keeps the carry of the add in the top bit before shifting right;
    // divide shifts the next dividend bit into the remainder and trial-subtracts.
    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? operand : {WIDTH{1'b0}})};
        shifted  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff     = shifted - {1'b0, operand};
        acc_next = {sum, acc[WIDTH-1:1]};
        if (is_div) begin
            if (diff[WIDTH]) begin
                acc_next = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end else begin
                acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end
        end
    end

endmodule

// File: rtl/mdu_iterative.sv
// Multi-cycle MIPS multiply/divide unit owning HI/LO; one result bit per cycle
// on magnitudes, with signs restored in a final fix-up cycle.
module mdu_iterative
    import mdu_iterative_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             hi_we,
    input  logic             lo_we,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    mdu_state_e state, state_next;

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH-1:0]   operand;
    logic [CNT_W-1:0]   cnt;
    logic               is_div;
    logic               neg_lo;
    logic               neg_hi;

    logic               op_div;
    logic               op_signed;
    logic               x_neg;
    logic               y_neg;
    logic [WIDTH-1:0]   x_mag;
    logic [WIDTH-1:0]   y_mag;
    logic               last_iter;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic               dz;

    mdu_iterative_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (is_div),
        .acc      (acc),
        .operand  (operand),
        .acc_next (acc_step)
    );

    always_comb begin
        op_div    = (op == MDU_OP_DIV) || (op == MDU_OP_DIVU);
        op_signed = (op == MDU_OP_MULT) || (op == MDU_OP_DIV);
        x_neg     = op_signed & x[WIDTH-1];
        y_neg     = op_signed & y[WIDTH-1];
        x_mag     = x_neg ? (~x + 1'b1) : x;
        y_mag     = y_neg ? (~y + 1'b1) : y;
        last_iter = (cnt == CNT_W'(WIDTH - 1));
        prod      = neg_lo ? (~acc + 1'b1) : acc;
        quo       = neg_lo ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
        rem       = neg_hi ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
        dz        = is_div && (operand == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MDU_S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            MDU_S_IDLE: if (start) state_next = MDU_S_CALC;
            MDU_S_CALC: if (last_iter) state_next = MDU_S_FIX;
            MDU_S_FIX:  state_next = MDU_S_IDLE;
            default:    state_next = MDU_S_IDLE;
        endcase
    end

    // MTHI/MTLO land first so a result written on the same edge overrides them.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            acc      <= '0;
            operand  <= '0;
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!busy) begin
                if (hi_we) hi <= x;
                if (lo_we) lo <= x;
            end
            case (state)
                MDU_S_IDLE: begin
                    if (start) begin
                        busy     <= 1'b1;
                        cnt      <= '0;
                        is_div   <= op_div;
                        div_zero <= 1'b0;
                        neg_lo   <= x_neg ^ y_neg;
                        neg_hi   <= op_div ? x_neg : (x_neg ^ y_neg);
                        // Multiply walks the multiplier from the low half;
                        // divide shifts the dividend out of the low half.
                        acc      <= {{WIDTH{1'b0}}, (op_div ? x_mag : y_mag)};
                        operand  <= op_div ? y_mag : x_mag;
                    end
                end
                MDU_S_CALC: begin
                    acc <= acc_step;
                    cnt <= cnt + 1'b1;
                end
                MDU_S_FIX: begin
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    div_zero <= dz;
                    if (is_div) begin
                        hi <= rem;
                        lo <= dz ? {WIDTH{1'b1}} : quo;
                    end else begin
                        hi <= prod[2*WIDTH-1:WIDTH];
                        lo <= prod[WIDTH-1:0];
                    end
                end
                default: busy <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative: directed corner cases plus random
// operations compared against a plain-arithmetic reference model.
module tb_mdu_iterative;
    import mdu_iterative_pkg::*;

    localparam int WIDTH = 32;
    localparam int CNT_W = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             hi_we;
    logic             lo_we;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    int checks = 0;
    int errors = 0;

    mdu_iterative #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .x        (x),
        .y        (y),
        .hi_we    (hi_we),
        .lo_we    (lo_we),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference results from MIPS rules using 64-bit signed/unsigned arithmetic.
    function automatic void refModel(input logic [1:0] mop, input logic [31:0] mx, input logic [31:0] my,
                                     output logic [31:0] ehi, output logic [31:0] elo, output logic edz);
        longint sx, sy, ux, uy, p, q, r;
        sx  = longint'($signed(mx));
        sy  = longint'($signed(my));
        ux  = longint'({32'b0, mx});
        uy  = longint'({32'b0, my});
        edz = 1'b0;
        ehi = '0;
        elo = '0;
        case (mop)
            MDU_OP_MULT, MDU_OP_MULTU: begin
                p   = (mop == MDU_OP_MULT) ? sx * sy : ux * uy;
                ehi = p[63:32];
                elo = p[31:0];
            end
            default: begin
                if (my == 32'd0) begin
                    elo = 32'hFFFF_FFFF;
                    ehi = mx;
                    edz = 1'b1;
                end else begin
                    q   = (mop == MDU_OP_DIV) ? sx / sy : ux / uy;
                    r   = (mop == MDU_OP_DIV) ? sx % sy : ux % uy;
                    elo = q[31:0];
                    ehi = r[31:0];
                end
            end
        endcase
    endfunction

    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op    = o;
        x     = a;
        y     = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
    endtask

    task automatic runOp(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ehi, elo;
        logic        edz;
        int          n, bc;
        refModel(o, a, b, ehi, elo, edz);
        applyStimulus(o, a, b);
        @(negedge clk);
        n  = 1;
        bc = busy ? 1 : 0;
        checkOutput("dz_clear_at_start", 64'(div_zero), 64'd0);
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
            if (busy) bc++;
        end
        checkOutput("latency", 64'(n), 64'(WIDTH + 2));
        checkOutput("busy_cycles", 64'(bc), 64'(WIDTH + 1));
        checkOutput("hi", 64'(hi), 64'(ehi));
        checkOutput("lo", 64'(lo), 64'(elo));
        checkOutput("div_zero", 64'(div_zero), 64'(edz));
        @(negedge clk);
        checkOutput("done_single", 64'(done), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] hi_before;
        int          dc;

        rst   = 1'b1;
        start = 1'b0;
        op    = '0;
        x     = '0;
        y     = '0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_dz", 64'(div_zero), 64'd0);
        checkOutput("reset_hi", 64'(hi), 64'd0);
        checkOutput("reset_lo", 64'(lo), 64'd0);
        rst = 1'b0;

        runOp(MDU_OP_MULTU, 32'd100, 32'd200);
        runOp(MDU_OP_MULT, 32'hFFFF_FFFD, 32'd5);
        runOp(MDU_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        runOp(MDU_OP_DIV, 32'hFFFF_FFF9, 32'd2);
        runOp(MDU_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        runOp(MDU_OP_DIVU, 32'd7, 32'd0);
        runOp(MDU_OP_DIVU, 32'd9, 32'd3);
        runOp(MDU_OP_DIV, 32'hFFFF_FFF0, 32'd0);

        // Register writes on the start edge are overwritten by the result.
        hi_we = 1'b1;
        lo_we = 1'b1;
        runOp(MULTU_OR(MDU_OP_MULTU), 32'd2, 32'd3);

        for (int i = 0; i < 30; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(8, 28);
            runOp(2'($urandom_range(0, 3)), ra, rb);
        end

        // start and MTHI while busy must be ignored.
        hi_before = hi;
        applyStimulus(MDU_OP_MULTU, 32'd2, 32'd3);
        dc = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (k == 6) checkOutput("hi_we_ignored", 64'(hi), 64'(hi_before));
            if (done) begin
                dc++;
                checkOutput("ignore_hi", 64'(hi), 64'd0);
                checkOutput("ignore_lo", 64'(lo), 64'd6);
            end
            if (k == 4) begin
                start = 1'b1;
                op    = MDU_OP_DIVU;
                hi_we = 1'b1;
                x     = 32'h55;
                y     = 32'd1;
            end else begin
                start = 1'b0;
                hi_we = 1'b0;
            end
        end
        checkOutput("ignore_done_count", 64'(dc), 64'd1);

        @(negedge clk);
        hi_we = 1'b1;
        lo_we = 1'b1;
        x     = 32'h0000_A5A5;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b0;
        checkOutput("mthi_both", 64'(hi), 64'h0000_A5A5);
        checkOutput("mtlo_both", 64'(lo), 64'h0000_A5A5);

        // Abort a division with reset mid-flight.
        applyStimulus(MDU_OP_DIV, 32'd100, 32'd7);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_hi", 64'(hi), 64'd0);
        checkOutput("abort_lo", 64'(lo), 64'd0);
        dc = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) dc++;
        end
        checkOutput("abort_no_done", 64'(dc), 64'd0);

        lo_we = 1'b1;
        x     = 32'h0000_1234;
        @(negedge clk);
        lo_we = 1'b0;
        checkOutput("mtlo", 64'(lo), 64'h0000_1234);
        checkOutput("mtlo_hi_kept", 64'(hi), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    function automatic logic [1:0] MULTU_OR(input logic [1:0] o);
        return o;
    endfunction

endmodule
